// File: rtl/bus_demux_pkg.sv
// Shared types and constants for the bus demux buffer.
// Slot state and channel select encodings.
package bus_demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer with valid/ack handshake.
// Also counts words accepted into this slot (wrapping).
module demux_slot
    import bus_demux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 ack_i,
    input  logic [WIDTH-1:0]     din_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    output logic                 avail_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    slot_state_t          state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // An ack this cycle frees the slot, enabling back-to-back transfers.
    assign avail_o = (state_q == SLOT_EMPTY) || ack_i;
    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign count_o = count_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = din_i;
            count_d = count_q + 1'b1;
        end else if (ack_i && state_q == SLOT_FULL) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_demux_buffer.sv
// Steers a shared bus into one of two buffered channels.
// Backpressure follows the selected channel's slot availability.
module bus_demux_buffer
    import bus_demux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sel,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     out0,
    output logic                 out0_valid,
    input  logic                 out0_ack,
    output logic [WIDTH-1:0]     out1,
    output logic                 out1_valid,
    input  logic                 out1_ack,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    logic avail0, avail1;
    logic xfer, load0, load1;

    assign in_ready = (sel == CH1) ? avail1 : avail0;
    assign xfer     = in_valid && in_ready;
    assign load0    = xfer && (sel == CH0);
    assign load1    = xfer && (sel == CH1);

    demux_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot0 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load0),
        .ack_i   (out0_ack),
        .din_i   (din),
        .data_o  (out0),
        .valid_o (out0_valid),
        .avail_o (avail0),
        .count_o (count0)
    );

    demux_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot1 (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load1),
        .ack_i   (out1_ack),
        .din_i   (din),
        .data_o  (out1),
        .valid_o (out1_valid),
        .avail_o (avail1),
        .count_o (count1)
    );

endmodule

// File: tb/tb_bus_demux_buffer.sv
// Randomized bench for bus_demux_buffer against a
// behavioural two-channel buffer model.
module tb_bus_demux_buffer;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          sel;
    logic [W-1:0]  din;
    logic [W-1:0]  out0, out1;
    logic          out0_valid, out1_valid;
    logic          out0_ack, out1_ack;
    logic [CW-1:0] count0, count1;

    int checks = 0;
    int errors = 0;

    // Model: per channel, is a word held, its value, words accepted.
    bit m_full [2];
    int m_data [2];
    int m_cnt  [2];

    always #5 clk = ~clk;

    bus_demux_buffer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .din        (din),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ack   (out0_ack),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ack   (out1_ack),
        .count0     (count0),
        .count1     (count1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 0;
            m_data[c] = 0;
            m_cnt[c]  = 0;
        end
    endtask

    function automatic bit m_ready(input int c, input bit ack);
        return !m_full[c] || ack;
    endfunction

    task automatic check_outs();
        check("out0", int'(out0), m_data[0]);
        check("out0_valid", int'(out0_valid), int'(m_full[0]));
        check("count0", int'(count0), m_cnt[0]);
        check("out1", int'(out1), m_data[1]);
        check("out1_valid", int'(out1_valid), int'(m_full[1]));
        check("count1", int'(count1), m_cnt[1]);
    endtask

    // Apply one cycle of stimulus; check ready before the edge,
    // outputs just after it.
    task automatic step(input bit v, input bit s, input int d,
                        input bit a0, input bit a1);
        bit ack [2];
        bit rdy;
        in_valid = v;
        sel      = s;
        din      = W'(d);
        out0_ack = a0;
        out1_ack = a1;
        ack[0]   = a0;
        ack[1]   = a1;
        #1;
        rdy = m_ready(int'(s), ack[s]);
        check("in_ready", int'(in_ready), int'(rdy));
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (v && rdy && int'(s) == c) begin
                m_full[c] = 1;
                m_data[c] = d % (1 << W);
                m_cnt[c]  = (m_cnt[c] + 1) % (1 << CW);
            end else if (ack[c]) begin
                m_full[c] = 0;
            end
        end
        #1;
        check_outs();
    endtask

    initial begin
        int c1_before;
        reset    = 1'b1;
        in_valid = 1'b0;
        sel      = 1'b0;
        din      = '0;
        out0_ack = 1'b0;
        out1_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outs();
        check("in_ready_rst", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed sequence from the plan
        step(1, 0, 'hA, 0, 0);
        check("plan_out0_A", int'(out0), 'hA);
        check("plan_count0_1", int'(count0), 1);
        step(1, 0, 'h5, 0, 0);
        check("plan_out0_hold", int'(out0), 'hA);
        step(1, 1, 'h5, 0, 0);
        check("plan_out1_5", int'(out1), 'h5);
        step(1, 0, 'h3, 1, 0);
        check("plan_out0_3", int'(out0), 'h3);
        check("plan_count0_2", int'(count0), 2);
        step(0, 0, 0, 0, 1);
        check("plan_out1_hold", int'(out1), 'h5);
        check("plan_out1_valid", int'(out1_valid), 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 15),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        // 256 back-to-back words into channel 1
        c1_before = m_cnt[1];
        for (int i = 0; i < 256; i++) begin
            step(1, 1, $urandom_range(0, 15), $urandom_range(0, 1), 1);
        end
        check("wrap_count1", int'(count1), c1_before);

        // Async reset mid-cycle with both slots full
        step(1, 0, 'h7, 1, 0);
        step(1, 1, 'h9, 0, 1);
        in_valid = 1'b1;
        sel      = 1'b0;
        din      = 4'hE;
        out0_ack = 1'b1;
        out1_ack = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outs();
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 'hC, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
